// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: decode/execute/memory observations in, pipeline
// stall/flush controls and performance counters out.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       rs1_d;
   logic [4:0]       rs2_d;
   logic             uses_rs1_d;
   logic             uses_rs2_d;
   logic [4:0]       rd_x;
   logic             MemRead_x;
   logic             redirect_x;
   logic             mem_req_m;
   logic             mem_ready;
   logic             stall_f;
   logic             stall_d;
   logic             flush_d;
   logic             flush_x;
   logic             stall_x;
   logic             stall_m;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output rs1_d, rs2_d, uses_rs1_d, uses_rs2_d, rd_x, MemRead_x,
             redirect_x, mem_req_m, mem_ready,
      input  stall_f, stall_d, flush_d, flush_x, stall_x, stall_m, halted,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  rs1_d, rs2_d, uses_rs1_d, uses_rs2_d, rd_x, MemRead_x,
             redirect_x, mem_req_m, mem_ready,
      output stall_f, stall_d, flush_d, flush_x, stall_x, stall_m, halted,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage RV32I hazard controller: memory-wait freeze with timeout/halt,
// redirect flush, load-use bubble, and saturating stall/flush counters.
module hazard_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         reset,
   hazard_ctrl_if.slave bus
);
   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_t           r_state;
   logic [7:0]       r_wait_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic w_mem_block;
   logic w_freeze;
   logic w_redirect;
   logic w_load_use;
   logic w_src_match;
   logic w_stall_f;
   logic w_flush_d;

   always_comb begin
      w_mem_block = bus.mem_req_m && !bus.mem_ready;
      w_freeze    = (r_state == HALT) || w_mem_block;
      w_src_match = (bus.uses_rs1_d && (bus.rs1_d == bus.rd_x)) ||
                    (bus.uses_rs2_d && (bus.rs2_d == bus.rd_x));
      w_redirect  = !w_freeze && bus.redirect_x;
      // Redirect wins over load-use: the dependent ID instruction is squashed anyway.
      w_load_use  = !w_freeze && !bus.redirect_x && bus.MemRead_x &&
                    (bus.rd_x != 5'd0) && w_src_match;
      w_stall_f   = !reset && (w_freeze || w_load_use);
      w_flush_d   = !reset && w_redirect;
   end

   assign bus.stall_f   = w_stall_f;
   assign bus.stall_d   = w_stall_f;
   assign bus.flush_d   = w_flush_d;
   assign bus.flush_x   = !reset && (w_redirect || w_load_use);
   assign bus.stall_x   = !reset && w_freeze;
   assign bus.stall_m   = !reset && w_freeze;
   assign bus.halted    = (r_state == HALT);
   assign bus.stall_cnt = r_stall_cnt;
   assign bus.flush_cnt = r_flush_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_mem_block) begin
                  r_state    <= MEM_WAIT;
                  r_wait_cnt <= 8'd1;
               end
            end
            MEM_WAIT: begin
               if (bus.mem_ready) begin
                  r_state    <= RUN;
                  r_wait_cnt <= '0;
               end else if (r_wait_cnt == TIMEOUT) begin
                  r_state <= HALT;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            HALT:    r_state <= HALT;
            default: r_state <= RUN;
         endcase
      end
   end

   // Counters saturate at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_f && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush_d && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations driven by shared stimulus, checked
// every cycle against a behavioural model, plus directed literal checks.
module tb_hazard_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] rs1_d, rs2_d, rd_x;
   logic       uses_rs1_d, uses_rs2_d, MemRead_x, redirect_x, mem_req_m, mem_ready;

   // {stall_f, stall_d, flush_d, flush_x, stall_x, stall_m, halted}
   logic [6:0]  ctrl_o [2];
   logic [15:0] scnt_o [2];
   logic [15:0] fcnt_o [2];

   int n_total = 0;
   int n_pass  = 0;

   initial forever #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int CW = (gi == 0) ? 16 : 4;
      localparam int TO = (gi == 0) ? 4 : 255;
      hazard_ctrl_if #(.CNT_W(CW)) bus ();
      assign bus.rs1_d      = rs1_d;
      assign bus.rs2_d      = rs2_d;
      assign bus.uses_rs1_d = uses_rs1_d;
      assign bus.uses_rs2_d = uses_rs2_d;
      assign bus.rd_x       = rd_x;
      assign bus.MemRead_x  = MemRead_x;
      assign bus.redirect_x = redirect_x;
      assign bus.mem_req_m  = mem_req_m;
      assign bus.mem_ready  = mem_ready;
      hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) u_dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );
      assign ctrl_o[gi] = {bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_x,
                           bus.stall_x, bus.stall_m, bus.halted};
      assign scnt_o[gi] = 16'(bus.stall_cnt);
      assign fcnt_o[gi] = 16'(bus.flush_cnt);
   end

   // ---------------- behavioural model ----------------
   bit m_halted [2];
   int m_run    [2];
   int m_scnt   [2];
   int m_fcnt   [2];

   function automatic int tmo(int i);
      return (i == 0) ? 4 : 255;
   endfunction

   function automatic int cmax(int i);
      return (i == 0) ? 65535 : 15;
   endfunction

   function automatic logic [6:0] exp_ctrl(int i);
      bit frz, lu;
      if (reset) return 7'b0;
      frz = m_halted[i] || (mem_req_m && !mem_ready);
      lu  = MemRead_x && (rd_x != 5'd0) &&
            ((uses_rs1_d && rs1_d == rd_x) || (uses_rs2_d && rs2_d == rd_x));
      if (frz)             return {6'b110011, m_halted[i]};
      else if (redirect_x) return {6'b001100, m_halted[i]};
      else if (lu)         return {6'b110100, m_halted[i]};
      return {6'b000000, m_halted[i]};
   endfunction

   always @(posedge clk or posedge reset) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_halted[i] <= 1'b0;
            m_run[i]    <= 0;
            m_scnt[i]   <= 0;
            m_fcnt[i]   <= 0;
         end else begin
            if (|(exp_ctrl(i) & 7'b1000000))
               m_scnt[i] <= (m_scnt[i] < cmax(i)) ? m_scnt[i] + 1 : m_scnt[i];
            if (|(exp_ctrl(i) & 7'b0010000))
               m_fcnt[i] <= (m_fcnt[i] < cmax(i)) ? m_fcnt[i] + 1 : m_fcnt[i];
            if (!m_halted[i]) begin
               if (mem_req_m && !mem_ready) begin
                  m_run[i] <= m_run[i] + 1;
                  if (m_run[i] + 1 == tmo(i) + 1) m_halted[i] <= 1'b1;
               end else begin
                  m_run[i] <= 0;
               end
            end
         end
      end
   end

   task automatic check(string nm, int idx, logic [15:0] act, logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d] t=%0t: got %0h expected %0h", nm, idx, $time, act, exp);
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         check("model_ctrl", i, 16'(ctrl_o[i]), 16'(exp_ctrl(i)));
         check("model_scnt", i, scnt_o[i], 16'(m_scnt[i]));
         check("model_fcnt", i, fcnt_o[i], 16'(m_fcnt[i]));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      rs1_d = 0; rs2_d = 0; rd_x = 0; uses_rs1_d = 0; uses_rs2_d = 0;
      MemRead_x = 0; redirect_x = 0; mem_req_m = 0; mem_ready = 0;
   endtask

   initial begin
      bit pend;
      clear_in();
      redirect_x = 1; mem_req_m = 1;
      @(negedge clk);
      check("rst_ctrl", 0, 16'(ctrl_o[0]), 16'h0);
      check("rst_scnt", 0, scnt_o[0], 16'h0);
      #2 reset = 0;
      clear_in();

      // load-use
      cyc(); MemRead_x = 1; rd_x = 5; rs2_d = 5; uses_rs2_d = 1;
      @(negedge clk); check("lu_ctrl", 0, 16'(ctrl_o[0]), 16'(7'b1101000));
      cyc(); clear_in();
      @(negedge clk); check("lu_scnt", 0, scnt_o[0], 16'd1);
      check("lu_clear", 0, 16'(ctrl_o[0]), 16'h0);
      cyc(); MemRead_x = 1; rd_x = 0; rs2_d = 0; uses_rs2_d = 1;
      @(negedge clk); check("lu_x0", 0, 16'(ctrl_o[0]), 16'h0);

      // redirect overrides load-use
      cyc(); MemRead_x = 1; rd_x = 5; rs2_d = 5; uses_rs2_d = 1; redirect_x = 1;
      @(negedge clk); check("redir_lu", 0, 16'(ctrl_o[0]), 16'(7'b0011000));
      cyc(); clear_in();
      @(negedge clk); check("redir_fcnt", 0, fcnt_o[0], 16'd1);
      check("redir_scnt", 0, scnt_o[0], 16'd1);

      // three-cycle memory wait
      for (int k = 0; k < 3; k++) begin
         cyc(); mem_req_m = 1; mem_ready = 0;
         @(negedge clk); check("memw_ctrl", 0, 16'(ctrl_o[0]), 16'(7'b1100110));
      end
      cyc(); mem_ready = 1;
      @(negedge clk); check("memw_rel", 0, 16'(ctrl_o[0]), 16'h0);
      cyc(); clear_in();
      @(negedge clk); check("memw_scnt", 0, scnt_o[0], 16'd4);

      // redirect deferred across a two-cycle wait
      for (int k = 0; k < 2; k++) begin
         cyc(); mem_req_m = 1; mem_ready = 0; redirect_x = 1;
         @(negedge clk); check("defer_ctrl", 0, 16'(ctrl_o[0]), 16'(7'b1100110));
      end
      cyc(); mem_ready = 1;
      @(negedge clk); check("defer_rel", 0, 16'(ctrl_o[0]), 16'(7'b0011000));
      cyc(); clear_in();
      @(negedge clk); check("defer_fcnt", 0, fcnt_o[0], 16'd2);
      check("defer_scnt", 0, scnt_o[0], 16'd6);

      // timeout into halt (instance 0 has MEM_TIMEOUT=4)
      for (int k = 0; k < 5; k++) begin
         cyc(); mem_req_m = 1; mem_ready = 0;
         @(negedge clk); check("tmo_wait", 0, 16'(ctrl_o[0]), 16'(7'b1100110));
      end
      cyc();
      @(negedge clk); check("tmo_halt", 0, 16'(ctrl_o[0]), 16'(7'b1100111));
      cyc(); mem_req_m = 0; mem_ready = 1; redirect_x = 1;
      @(negedge clk); check("tmo_ignore", 0, 16'(ctrl_o[0]), 16'(7'b1100111));
      cyc(); clear_in();
      @(negedge clk); check("tmo_scnt", 0, scnt_o[0], 16'd13);
      check("tmo_fcnt", 0, fcnt_o[0], 16'd2);

      // asynchronous reset out of HALT
      #2 reset = 1;
      #1;
      check("arst_ctrl", 0, 16'(ctrl_o[0]), 16'h0);
      check("arst_scnt", 0, scnt_o[0], 16'h0);
      check("arst_fcnt", 0, fcnt_o[0], 16'h0);
      @(posedge clk); #1 reset = 0;
      @(negedge clk); check("arst_after", 0, 16'(ctrl_o[0]), 16'h0);

      // saturation on instance 1 (CNT_W=4)
      for (int k = 0; k < 20; k++) begin
         cyc(); mem_req_m = 1; mem_ready = 0;
      end
      @(negedge clk); check("sat_scnt", 1, scnt_o[1], 16'd15);
      cyc();
      @(negedge clk); check("sat_hold", 1, scnt_o[1], 16'd15);
      cyc(); reset = 1; clear_in();
      cyc(); reset = 0;

      // randomized phase, model-checked every cycle
      pend = 0;
      for (int n = 0; n < 3000; n++) begin
         cyc();
         if (reset) reset = 0;
         else if ($urandom_range(0, 99) == 0) begin
            reset = 1;
            pend  = 0;
         end
         rs1_d      = 5'($urandom_range(0, 7));
         rs2_d      = 5'($urandom_range(0, 7));
         rd_x       = 5'($urandom_range(0, 7));
         uses_rs1_d = 1'($urandom_range(0, 1));
         uses_rs2_d = 1'($urandom_range(0, 1));
         MemRead_x  = 1'($urandom_range(0, 1));
         redirect_x = ($urandom_range(0, 5) == 0);
         mem_req_m  = pend ? 1'b1 : ($urandom_range(0, 2) == 0);
         mem_ready  = ($urandom_range(0, 2) != 0);
         pend       = mem_req_m && !mem_ready;
      end
      cyc();
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It watches decode-stage source registers, the instruction in Execute, EX-stage redirects and the data-memory handshake, and drives the stall and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers. It owns the multi-cycle memory-wait state machine, a memory timeout with halt, and two saturating performance counters.

## Interface
- CNT_W, 16: width of the performance counters.
- MEM_TIMEOUT, 255: maximum consecutive memory-wait cycles before halt (range 1..255).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- rs1_d, rs2_d  in  5 each  source register indices of the instruction in ID.
- uses_rs1_d, uses_rs2_d  in  1 each  the ID instruction reads rs1 / rs2.
- rd_x  in  5  destination register of the instruction in EX.
- MemRead_x  in  1  the EX instruction is a load.
- redirect_x  in  1  taken branch or jump resolved in EX.
- mem_req_m  in  1  the MEM instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold IF/ID.
- flush_d  out  1  clear IF/ID to NOP.
- flush_x  out  1  bubble into ID/EX (control fields cleared).
- stall_x  out  1  hold ID/EX.
- stall_m  out  1  hold EX/MEM.
- halted  out  1  memory timeout occurred; sticky until reset.
- stall_cnt  out  CNT_W  cycles with stall_f=1.
- flush_cnt  out  CNT_W  redirect flush events.

## Operation
- States: RUN, MEM_WAIT, HALT. Internal 8-bit wait_cnt.
- freeze = (mem_req_m && !mem_ready && state!=HALT) || state==HALT. When freeze=1: stall_f=stall_d=stall_x=stall_m=1; flush_d=flush_x=0. Freeze has top priority.
- Redirect, when not frozen and redirect_x=1: flush_d=1, flush_x=1, all stalls 0. This overrides load-use, because the dependent ID instruction is discarded.
- Load-use, when not frozen, no redirect, MemRead_x=1, rd_x!=0 and ((uses_rs1_d && rs1_d==rd_x) || (uses_rs2_d && rs2_d==rd_x)): stall_f=stall_d=1 and flush_x=1 for one cycle. stall_x=stall_m=0.
- Otherwise every control output is 0.
- RUN: if mem_req_m && !mem_ready, go to MEM_WAIT with wait_cnt=1.
- MEM_WAIT:
  - mem_ready=1: freeze releases the same cycle; go to RUN and clear wait_cnt.
  - mem_ready=0 and wait_cnt==MEM_TIMEOUT: go to HALT.
  - Otherwise increment wait_cnt.
- HALT: permanent freeze and halted=1 until reset. All inputs are ignored.
- Stall and flush outputs are combinational from the inputs and state. halted is decoded from state.
- Counter updates (both saturate at 2^CNT_W−1 and never wrap):
  - stall_cnt increments on each clk edge where stall_f=1, including freeze and HALT cycles.
  - flush_cnt increments on each edge where the redirect condition drives flush_d.

## Timing
- Reset values: state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, halted=0.
- While reset is high, all stall and flush outputs are forced to 0.
- Reset asserted mid-MEM_WAIT or mid-HALT returns to RUN immediately (asynchronous).
- Load-use latency: exactly one bubble. The next cycle the load is in MEM, so the condition clears naturally.
- Redirect latency: one cycle. The wrong-path instructions in IF/ID and ID/EX are squashed at the next edge.
- A redirect_x arriving during a freeze is deferred. EX is held, so redirect_x stays asserted and acts on the first unfrozen cycle. It is counted once.
- A memory access with mem_ready=1 in its first cycle causes no stall and no state change.
- The timeout is reached after MEM_TIMEOUT+1 frozen cycles; HALT is entered on that edge.

## Test plan
- Load-use:
  - Stimulus: MemRead_x=1, rd_x=5, rs2_d=5, uses_rs2_d=1.
  - Response: one cycle of stall_f=stall_d=flush_x=1; stall_cnt goes 0→1.
  - Repeat with rd_x=0: no stall.
- Redirect plus load-use:
  - Stimulus: redirect_x=1 together with a load-use match.
  - Response: flush_d=flush_x=1, stall_f=0; flush_cnt goes 0→1.
- Memory wait:
  - Stimulus: mem_req_m=1, mem_ready=0 for 3 cycles, then 1.
  - Response: all four stalls high for 3 cycles, low on the ready cycle; state returns to RUN; stall_cnt=3.
- Deferred redirect:
  - Stimulus: redirect_x=1 held across a 2-cycle memory wait.
  - Response: no flush during the wait; flush_d=flush_x=1 on the release cycle; flush_cnt increments by exactly 1.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, mem_ready held 0.
  - Response: halted=1 after 5 frozen cycles; stalls stay high when mem_ready later rises.
  - Then assert reset: halted=0, counters=0.
- Saturation:
  - Stimulus: CNT_W=4, continuous freeze.
  - Response: stall_cnt stops at 15 and never wraps.
